// File: rtl/counter_pkg.sv
// Shared types and helpers for the start-triggered cycle counter.
package counter_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Counter width, clamped to at least one bit so COUNT_NUM = 1 still elaborates.
  function automatic int cnt_width(input int count_num);
    int w;
    w = $clog2(count_num);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/counter.sv
// Start-triggered cycle counter: a start pulse times COUNT_NUM cycles, then done_o strobes once.
// Optional macro COUNTER_RESTART_EN: start_i while BUSY restarts the run instead of being ignored.
module counter
  import counter_pkg::*;
#(
  parameter int COUNT_NUM = 16,
  parameter int CNT_W     = cnt_width(COUNT_NUM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  output logic             done_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT_NUM - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (start_i) state <= BUSY;
        end
        BUSY: begin
`ifdef COUNTER_RESTART_EN
          // A restart beats completion on the same edge: the aborted run never reports done.
          if (start_i) begin
            cnt <= '0;
          end else
`endif
          if (cnt == LAST) begin
            done_q <= 1'b1;
            cnt    <= '0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign done_o  = done_q;
  assign busy_o  = (state == BUSY);
  assign count_o = cnt;

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter: directed scenarios plus random start/reset traffic
// compared every cycle against an edge-indexed reference model.
module tb_counter;

  localparam int N     = 16;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_i;
  logic             done_o;
  logic             busy_o;
  logic [CNT_W-1:0] count_o;

  int tests  = 0;
  int failed = 0;

  // Reference model: edge number of the accepted start of the current run (-1 = none).
  int k         = 0;
  int run_start = -1;
  logic             exp_done;
  logic             exp_busy;
  logic [CNT_W-1:0] exp_cnt;

  counter #(.COUNT_NUM(N), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .done_o  (done_o),
    .busy_o  (busy_o),
    .count_o (count_o)
  );

  always #5 clk = ~clk;

  task automatic model_edge(input logic s, input logic r);
    bit busy_before, completes, restart_en;
    restart_en = 1'b0;
`ifdef COUNTER_RESTART_EN
    restart_en = 1'b1;
`endif
    k++;
    exp_done = 1'b0;
    if (r) begin
      run_start = -1;
    end else begin
      busy_before = (run_start >= 0) && (k - run_start >= 1) && (k - run_start <= N);
      completes   = busy_before && (k - run_start == N);
      if (s && (!busy_before || restart_en)) begin
        run_start = k;
      end else if (completes) begin
        exp_done  = 1'b1;
        run_start = -1;
      end
    end
    exp_busy = (run_start >= 0) && (k - run_start <= N - 1);
    exp_cnt  = exp_busy ? CNT_W'(k - run_start) : '0;
  endtask

  task automatic step(input logic s, input logic r, input string tag);
    start_i = s;
    rst     = r;
    @(posedge clk);
    model_edge(s, r);
    #1;
    tests++;
    assert (done_o === exp_done) else begin
      failed++;
      $error("FAIL %s done_o k=%0d got %b expected %b", tag, k, done_o, exp_done);
    end
    tests++;
    assert (busy_o === exp_busy) else begin
      failed++;
      $error("FAIL %s busy_o k=%0d got %b expected %b", tag, k, busy_o, exp_busy);
    end
    tests++;
    assert (count_o === exp_cnt) else begin
      failed++;
      $error("FAIL %s count_o k=%0d got %0d expected %0d", tag, k, count_o, exp_cnt);
    end
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, tag);
  endtask

  initial begin
    int done_seen;
    start_i = 1'b0;
    rst     = 1'b1;

    // Reset held two cycles with start toggling: nothing may start.
    step(1'b1, 1'b1, "reset");
    step(1'b0, 1'b1, "reset");
    step(1'b0, 1'b0, "post_reset");

    // Single run: done exactly N edges after the start edge.
    step(1'b1, 1'b0, "single");
    idle(N - 1, "single");
    step(1'b0, 1'b0, "single_done");
    tests++;
    assert (done_o === 1'b1 && busy_o === 1'b0) else begin
      failed++;
      $error("FAIL single_latency got done=%b busy=%b expected done=1 busy=0", done_o, busy_o);
    end
    idle(4, "single_after");

    // Two runs separated by 3 idle cycles.
    step(1'b1, 1'b0, "two_a");
    idle(N, "two_a");
    idle(3, "two_gap");
    step(1'b1, 1'b0, "two_b");
    idle(N + 2, "two_b");

    // Back-to-back: restart on the cycle done_o is high.
    step(1'b1, 1'b0, "b2b_a");
    idle(N, "b2b_a");
    step(1'b1, 1'b0, "b2b_b");
    done_seen = 0;
    for (int i = 0; i < N; i++) begin
      step(1'b0, 1'b0, "b2b_b");
      if (done_o === 1'b1) done_seen = i + 1;
    end
    tests++;
    assert (done_seen == N) else begin
      failed++;
      $error("FAIL b2b_latency got done after %0d edges expected %0d", done_seen, N);
    end
    idle(3, "b2b_after");

    // Start held high through the run (ignored, or restart when enabled).
    step(1'b1, 1'b0, "held");
    idle(4, "held");
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, "held_hi");
    idle(N + 4, "held_tail");

    // Reset mid-run at E8 aborts without done, then a fresh run completes.
    step(1'b1, 1'b0, "midrst");
    idle(7, "midrst");
    step(1'b0, 1'b1, "midrst_rst");
    idle(N + 2, "midrst_quiet");
    step(1'b1, 1'b0, "midrst_new");
    idle(N + 2, "midrst_new");

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 79) == 0), "random");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
